// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, runs one outstanding req/gnt/rvalid
// transaction to instruction memory and hands fetched words to decode over valid/ready.
module fetch_sequencer #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   halt_i,
   input  logic [1:0]             redirect_sel_i,
   input  logic [ADDR_WIDTH-1:0]  tgt_addr_i,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
   input  logic [31:0]            offset_i,
   input  logic                   branch_tkn_i,
   output logic                   imem_req_o,
   output logic [ADDR_WIDTH-1:0]  imem_addr_o,
   input  logic                   imem_gnt_i,
   input  logic                   imem_rvalid_i,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
   output logic                   instr_valid_o,
   input  logic                   instr_ready_i,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0]  instr_pc_o,
   output logic [ADDR_WIDTH-1:0]  instr_pc_plus4_o,
   output logic [1:0]             dbg_state_o
);

   // Handshakes: imem accepts a request on a cycle with imem_req_o && imem_gnt_i and
   // returns exactly one imem_rvalid_i later; decode takes instr_o on a cycle with
   // instr_valid_o && instr_ready_i, and instr_o/instr_pc_o hold until then.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam logic [1:0] SEL_JUMP   = 2'b01;
   localparam logic [1:0] SEL_BRANCH = 2'b10;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_fetch_pc;
   logic                    r_drop_pending;
   logic                    r_instr_valid;
   logic [INSTR_WIDTH-1:0]  r_instr;
   logic [ADDR_WIDTH-1:0]   r_instr_pc;

   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   w_pc_nxt;
   logic                    w_drop_nxt;
   logic                    w_valid_nxt;
   logic                    w_capture;
   logic                    w_redir;
   logic [ADDR_WIDTH-1:0]   w_offset;
   logic [ADDR_WIDTH-1:0]   w_target_raw;
   logic [ADDR_WIDTH-1:0]   w_target;
   logic [ADDR_WIDTH-1:0]   w_pc_plus4;

   assign w_redir      = (redirect_sel_i == SEL_JUMP) ||
                         ((redirect_sel_i == SEL_BRANCH) && branch_tkn_i);
   assign w_offset     = ADDR_WIDTH'($signed(offset_i));
   assign w_target_raw = (redirect_sel_i == SEL_JUMP) ? tgt_addr_i : (redirect_pc_i + w_offset);
   assign w_target     = {w_target_raw[ADDR_WIDTH-1:2], 2'b00};
   assign w_pc_plus4   = r_fetch_pc + ADDR_WIDTH'(32'd4);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_fetch_pc;
      w_drop_nxt  = r_drop_pending;
      w_valid_nxt = r_instr_valid;
      w_capture   = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (!halt_i) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (imem_gnt_i) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               if (r_drop_pending) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = halt_i ? S_IDLE : S_REQ;
               end else begin
                  w_capture   = 1'b1;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (instr_ready_i) begin
               w_valid_nxt = 1'b0;
               w_pc_nxt    = w_pc_plus4;
               w_state_nxt = halt_i ? S_IDLE : S_REQ;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // A redirect overrides everything above; any response already owed is dropped.
      if (w_redir) begin
         w_pc_nxt  = w_target;
         w_capture = 1'b0;
         unique case (r_state)
            S_IDLE: w_state_nxt = halt_i ? S_IDLE : S_REQ;
            S_REQ: begin
               if (imem_gnt_i) begin
                  w_state_nxt = S_WAIT;
                  w_drop_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_REQ;
               end
            end
            S_WAIT: begin
               if (imem_rvalid_i) begin
                  w_drop_nxt  = 1'b0;
                  w_valid_nxt = r_instr_valid;
                  w_state_nxt = S_REQ;
               end else begin
                  w_drop_nxt  = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
            S_HOLD: begin
               w_valid_nxt = 1'b0;
               w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_fetch_pc     <= BOOT_ADDR;
         r_drop_pending <= 1'b0;
         r_instr_valid  <= 1'b0;
         r_instr        <= '0;
         r_instr_pc     <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_fetch_pc     <= w_pc_nxt;
         r_drop_pending <= w_drop_nxt;
         r_instr_valid  <= w_valid_nxt;
         if (w_capture) begin
            r_instr    <= imem_rdata_i;
            r_instr_pc <= r_fetch_pc;
         end
      end
   end

   assign imem_req_o       = (r_state == S_REQ);
   assign imem_addr_o      = r_fetch_pc;
   assign instr_valid_o    = r_instr_valid;
   assign instr_o          = r_instr;
   assign instr_pc_o       = r_instr_pc;
   assign instr_pc_plus4_o = r_instr_pc + ADDR_WIDTH'(32'd4);
   assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a parameterised memory responder plus one task per
// scenario, each checking DUT outputs on the falling edge against hand-computed values.
module tb_fetch_sequencer;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        halt_i = 1'b0;
   logic [1:0]  redirect_sel_i = 2'b00;
   logic [31:0] tgt_addr_i = '0;
   logic [31:0] redirect_pc_i = '0;
   logic [31:0] offset_i = '0;
   logic        branch_tkn_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b1;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic [31:0] instr_pc_plus4_o;
   logic [1:0]  dbg_state_o;

   int n_checks = 0;
   int n_fail   = 0;

   // responder configuration (written by tests) and internal state (written by responder)
   int  m_gnt_delay = 0;
   int  m_rv_lat    = 1;
   bit  m_keep      = 1'b0;
   int  m_wait_cnt;
   int  m_rv_cnt;
   logic [31:0] m_addr;

   fetch_sequencer #(
      .ADDR_WIDTH (32),
      .INSTR_WIDTH(32),
      .BOOT_ADDR  (32'h0000_0100)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .halt_i          (halt_i),
      .redirect_sel_i  (redirect_sel_i),
      .tgt_addr_i      (tgt_addr_i),
      .redirect_pc_i   (redirect_pc_i),
      .offset_i        (offset_i),
      .branch_tkn_i    (branch_tkn_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_gnt_i      (imem_gnt_i),
      .imem_rvalid_i   (imem_rvalid_i),
      .imem_rdata_i    (imem_rdata_i),
      .instr_valid_o   (instr_valid_o),
      .instr_ready_i   (instr_ready_i),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .instr_pc_plus4_o(instr_pc_plus4_o),
      .dbg_state_o     (dbg_state_o)
   );

   always #5 clk = ~clk;

   // Memory: grants after m_gnt_delay cycles of req, answers m_rv_lat cycles after gnt
   // with data 0xC0DE_<addr[15:0]>.
   initial begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      m_wait_cnt    = 0;
      m_rv_cnt      = 0;
      m_addr        = '0;
      forever begin
         @(negedge clk);
         imem_gnt_i    = 1'b0;
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = '0;
         if (!rst_n && !m_keep) begin
            m_wait_cnt = 0;
            m_rv_cnt   = 0;
         end else begin
            if (m_rv_cnt > 0) begin
               m_rv_cnt = m_rv_cnt - 1;
               if (m_rv_cnt == 0) begin
                  imem_rvalid_i = 1'b1;
                  imem_rdata_i  = 32'hC0DE_0000 | {16'h0, m_addr[15:0]};
               end
            end
            if (imem_req_o) begin
               if (m_wait_cnt >= m_gnt_delay) begin
                  imem_gnt_i = 1'b1;
                  m_addr     = imem_addr_o;
                  m_rv_cnt   = m_rv_lat;
                  m_wait_cnt = 0;
               end else begin
                  m_wait_cnt = m_wait_cnt + 1;
               end
            end else begin
               m_wait_cnt = 0;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_reset();
      rst_n          = 1'b0;
      halt_i         = 1'b0;
      redirect_sel_i = 2'b00;
      tgt_addr_i     = '0;
      redirect_pc_i  = '0;
      offset_i       = '0;
      branch_tkn_i   = 1'b0;
      step(3);
   endtask

   // Releases reset on a falling edge; that cycle is T0 and step(k) then lands on Tk.
   task automatic release_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      m_gnt_delay = 0; m_rv_lat = 1; instr_ready_i = 1'b1;
      hold_reset();
      n_checks++; if (dbg_state_o !== S_IDLE) begin n_fail++; $display("FAIL rst_state got %0d exp %0d", dbg_state_o, S_IDLE); end
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_req_o); end
      n_checks++; if (imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL rst_addr got %h exp 00000100", imem_addr_o); end
      n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", instr_valid_o); end
      n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 00000000", instr_o); end
      n_checks++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 00000000", instr_pc_o); end
      n_checks++; if (instr_pc_plus4_o !== 32'h4) begin n_fail++; $display("FAIL rst_pc4 got %h exp 00000004", instr_pc_plus4_o); end
   endtask

   task automatic test_zero_wait();
      m_gnt_delay = 0; m_rv_lat = 1; instr_ready_i = 1'b1;
      hold_reset(); release_reset();
      step(1);
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL zw_t1_req got req=%b addr=%h exp req=1 addr=00000100", imem_req_o, imem_addr_o); end
      step(2);
      n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h100) begin n_fail++; $display("FAIL zw_t3 got v=%b pc=%h exp v=1 pc=00000100", instr_valid_o, instr_pc_o); end
      n_checks++; if (instr_o !== 32'hC0DE0100) begin n_fail++; $display("FAIL zw_t3_instr got %h exp c0de0100", instr_o); end
      n_checks++; if (instr_pc_plus4_o !== 32'h104) begin n_fail++; $display("FAIL zw_t3_pc4 got %h exp 00000104", instr_pc_plus4_o); end
      step(1);
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h104 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL zw_t4 got req=%b addr=%h v=%b exp req=1 addr=00000104 v=0", imem_req_o, imem_addr_o, instr_valid_o); end
      step(2);
      n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h104 || instr_o !== 32'hC0DE0104) begin n_fail++; $display("FAIL zw_t6 got v=%b pc=%h i=%h exp v=1 pc=00000104 i=c0de0104", instr_valid_o, instr_pc_o, instr_o); end
      step(3);
      n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h108 || instr_o !== 32'hC0DE0108) begin n_fail++; $display("FAIL zw_t9 got v=%b pc=%h i=%h exp v=1 pc=00000108 i=c0de0108", instr_valid_o, instr_pc_o, instr_o); end
   endtask

   task automatic test_slow_memory();
      m_gnt_delay = 3; m_rv_lat = 2; instr_ready_i = 1'b1;
      hold_reset(); release_reset();
      for (int i = 1; i <= 4; i++) begin
         step(1);
         n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL slow_req_t%0d got req=%b addr=%h exp req=1 addr=00000100", i, imem_req_o, imem_addr_o); end
      end
      step(1);
      n_checks++; if (dbg_state_o !== S_WAIT || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL slow_t5 got st=%0d req=%b exp st=2 req=0", dbg_state_o, imem_req_o); end
      step(1);
      n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL slow_t6_valid got %b exp 0", instr_valid_o); end
      step(1);
      n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h100 || instr_o !== 32'hC0DE0100) begin n_fail++; $display("FAIL slow_t7 got v=%b pc=%h i=%h exp v=1 pc=00000100 i=c0de0100", instr_valid_o, instr_pc_o, instr_o); end
      step(1);
      n_checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h104) begin n_fail++; $display("FAIL slow_t8 got v=%b req=%b addr=%h exp v=0 req=1 addr=00000104", instr_valid_o, imem_req_o, imem_addr_o); end
      step(6);
      n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h104) begin n_fail++; $display("FAIL slow_t14 got v=%b pc=%h exp v=1 pc=00000104", instr_valid_o, instr_pc_o); end
   endtask

   task automatic test_backpressure();
      m_gnt_delay = 0; m_rv_lat = 1; instr_ready_i = 1'b0;
      hold_reset(); release_reset();
      step(3);
      for (int i = 3; i <= 8; i++) begin
         n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h100 || instr_o !== 32'hC0DE0100 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_hold_t%0d got v=%b pc=%h i=%h req=%b exp v=1 pc=00000100 i=c0de0100 req=0", i, instr_valid_o, instr_pc_o, instr_o, imem_req_o); end
         if (i < 8) step(1);
      end
      instr_ready_i = 1'b1;
      step(1);
      n_checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h104) begin n_fail++; $display("FAIL bp_release got v=%b req=%b addr=%h exp v=0 req=1 addr=00000104", instr_valid_o, imem_req_o, imem_addr_o); end
   endtask

   task automatic test_jump_in_wait();
      m_gnt_delay = 0; m_rv_lat = 3; instr_ready_i = 1'b1;
      hold_reset(); release_reset();
      step(2);
      redirect_sel_i = 2'b01; tgt_addr_i = 32'h203;
      step(1);
      redirect_sel_i = 2'b00; tgt_addr_i = '0;
      n_checks++; if (dbg_state_o !== S_WAIT || imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL jmp_t3 got st=%0d addr=%h exp st=2 addr=00000200", dbg_state_o, imem_addr_o); end
      step(1);
      n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL jmp_t4_valid got %b exp 0", instr_valid_o); end
      step(1);
      n_checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL jmp_t5 got v=%b req=%b addr=%h exp v=0 req=1 addr=00000200", instr_valid_o, imem_req_o, imem_addr_o); end
      step(4);
      n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h200 || instr_o !== 32'hC0DE0200) begin n_fail++; $display("FAIL jmp_t9 got v=%b pc=%h i=%h exp v=1 pc=00000200 i=c0de0200", instr_valid_o, instr_pc_o, instr_o); end
   endtask

   task automatic test_branch();
      m_gnt_delay = 0; m_rv_lat = 1; instr_ready_i = 1'b1;
      hold_reset(); release_reset();
      step(3);
      redirect_sel_i = 2'b10; redirect_pc_i = 32'h40; offset_i = 32'hFFFF_FFF8; branch_tkn_i = 1'b1;
      step(1);
      redirect_sel_i = 2'b00; branch_tkn_i = 1'b0;
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h38 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL br_taken got req=%b addr=%h v=%b exp req=1 addr=00000038 v=0", imem_req_o, imem_addr_o, instr_valid_o); end
      step(2);
      n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h38 || instr_o !== 32'hC0DE0038) begin n_fail++; $display("FAIL br_deliver got v=%b pc=%h i=%h exp v=1 pc=00000038 i=c0de0038", instr_valid_o, instr_pc_o, instr_o); end
      redirect_sel_i = 2'b10; branch_tkn_i = 1'b0;
      step(1);
      redirect_sel_i = 2'b00;
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3C) begin n_fail++; $display("FAIL br_not_taken got req=%b addr=%h exp req=1 addr=0000003c", imem_req_o, imem_addr_o); end
      redirect_pc_i = '0; offset_i = '0;
   endtask

   task automatic test_wrap();
      m_gnt_delay = 0; m_rv_lat = 1; instr_ready_i = 1'b1;
      hold_reset(); release_reset();
      step(3);
      redirect_sel_i = 2'b01; tgt_addr_i = 32'hFFFF_FFFF;
      step(1);
      redirect_sel_i = 2'b00;
      n_checks++; if (imem_addr_o !== 32'hFFFF_FFFC || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL wrap_tgt got addr=%h req=%b exp addr=fffffffc req=1", imem_addr_o, imem_req_o); end
      step(2);
      n_checks++; if (instr_pc_o !== 32'hFFFF_FFFC || instr_pc_plus4_o !== 32'h0 || instr_o !== 32'hC0DEFFFC) begin n_fail++; $display("FAIL wrap_hold got pc=%h pc4=%h i=%h exp pc=fffffffc pc4=00000000 i=c0defffc", instr_pc_o, instr_pc_plus4_o, instr_o); end
      redirect_sel_i = 2'b11; tgt_addr_i = 32'h500;
      step(1);
      redirect_sel_i = 2'b00; tgt_addr_i = '0;
      n_checks++; if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL wrap_next got addr=%h req=%b exp addr=00000000 req=1", imem_addr_o, imem_req_o); end
   endtask

   task automatic test_halt();
      m_gnt_delay = 0; m_rv_lat = 1; instr_ready_i = 1'b1;
      hold_reset(); release_reset();
      step(2);
      halt_i = 1'b1;
      step(1);
      n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h100) begin n_fail++; $display("FAIL halt_deliver got v=%b pc=%h exp v=1 pc=00000100", instr_valid_o, instr_pc_o); end
      step(1);
      n_checks++; if (dbg_state_o !== S_IDLE || imem_req_o !== 1'b0 || imem_addr_o !== 32'h104) begin n_fail++; $display("FAIL halt_idle got st=%0d req=%b addr=%h exp st=0 req=0 addr=00000104", dbg_state_o, imem_req_o, imem_addr_o); end
      step(1);
      n_checks++; if (dbg_state_o !== S_IDLE || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL halt_stay got st=%0d req=%b v=%b exp st=0 req=0 v=0", dbg_state_o, imem_req_o, instr_valid_o); end
      halt_i = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      m_gnt_delay = 0; m_rv_lat = 4; instr_ready_i = 1'b1;
      hold_reset(); release_reset();
      m_keep = 1'b1;
      step(2);
      n_checks++; if (dbg_state_o !== S_WAIT) begin n_fail++; $display("FAIL rmw_wait got st=%0d exp st=2", dbg_state_o); end
      rst_n = 1'b0; halt_i = 1'b1;
      step(1);
      n_checks++; if (dbg_state_o !== S_IDLE || imem_req_o !== 1'b0 || imem_addr_o !== 32'h100 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmw_reset got st=%0d req=%b addr=%h v=%b exp st=0 req=0 addr=00000100 v=0", dbg_state_o, imem_req_o, imem_addr_o, instr_valid_o); end
      rst_n = 1'b1;
      step(3);
      n_checks++; if (instr_valid_o !== 1'b0 || dbg_state_o !== S_IDLE) begin n_fail++; $display("FAIL rmw_late_rvalid got v=%b st=%0d exp v=0 st=0", instr_valid_o, dbg_state_o); end
      halt_i = 1'b0; m_rv_lat = 1; m_keep = 1'b0;
      step(1);
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL rmw_refetch got req=%b addr=%h exp req=1 addr=00000100", imem_req_o, imem_addr_o); end
      step(2);
      n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h100 || instr_o !== 32'hC0DE0100) begin n_fail++; $display("FAIL rmw_deliver got v=%b pc=%h i=%h exp v=1 pc=00000100 i=c0de0100", instr_valid_o, instr_pc_o, instr_o); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_slow_memory();
      test_backpressure();
      test_jump_in_wait();
      test_branch();
      test_wrap();
      test_halt();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
